// File: rtl/load_pkg.sv
// Shared load-path types: selector encoding, FSM states, size/signedness helpers.
package load_pkg;

  typedef enum logic [2:0] {
    SEL_LD      = 3'd0,
    SEL_LW      = 3'd1,
    SEL_LH      = 3'd2,
    SEL_LB      = 3'd3,
    SEL_LWU     = 3'd4,
    SEL_LHU     = 3'd5,
    SEL_LBU     = 3'd6,
    SEL_ILLEGAL = 3'd7
  } load_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD0   = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_RD1   = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } load_state_e;

  function automatic logic [3:0] load_size(input load_sel_e sel);
    case (sel)
      SEL_LD:           return 4'd8;
      SEL_LW, SEL_LWU:  return 4'd4;
      SEL_LH, SEL_LHU:  return 4'd2;
      default:          return 4'd1;
    endcase
  endfunction

  function automatic logic load_signed(input load_sel_e sel);
    return (sel == SEL_LD) || (sel == SEL_LW) || (sel == SEL_LH) || (sel == SEL_LB);
  endfunction

endpackage

// File: rtl/load_extend_core.sv
// Combinational shift/mask/extend of a two-beat window down to one XLEN result.
module load_extend_core
  import load_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic [2*XLEN-1:0] beats,
  input  logic [OFFW-1:0]   offset,
  input  load_sel_e         sel,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] shifted;
  logic            sign;

  assign shifted = XLEN'(beats >> {offset, 3'b000});

  always_comb begin
    sign = 1'b0;
    case (load_size(sel))
      4'd1:    sign = shifted[7];
      4'd2:    sign = shifted[15];
      4'd4:    sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    sign = sign & load_signed(sel);
    result = '0;
    for (int i = 0; i < XLEN; i++)
      result[i] = (i < 8 * int'(load_size(sel))) ? shifted[i] : sign;
  end

endmodule

// File: rtl/load_align_unit.sv
// Load-path FSM: fetch one or two memory words, align and extend to XLEN.
// Two-beat spanning loads are built only when LOAD_MISALIGN_EN is defined.
module load_align_unit
  import load_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_sel,
  input  logic [OFFW-1:0] req_offset,
  output logic            mem_req,
  output logic            mem_next,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  function automatic logic spans(input load_sel_e s, input logic [OFFW-1:0] o);
    return (int'(o) + int'(load_size(s))) > XLEN/8;
  endfunction

  function automatic logic illegal(input load_sel_e s);
    return (s == SEL_ILLEGAL) || (XLEN == 32 && (s == SEL_LD || s == SEL_LWU));
  endfunction

  load_state_e     state_q, state_d;
  load_sel_e       sel_in, sel_q;
  logic [OFFW-1:0] off_q;
  logic [XLEN-1:0] beat0_q;
  logic [XLEN-1:0] beat1;
  logic [XLEN-1:0] ext;
  logic            err_q;
  logic            req_bad;

  assign sel_in = load_sel_e'(req_sel);

`ifdef LOAD_MISALIGN_EN
  logic [XLEN-1:0] beat1_q;
  assign req_bad = illegal(sel_in);
  assign beat1   = beat1_q;
`else
  // Without the two-beat path a spanning access is rejected up front.
  assign req_bad = illegal(sel_in) || spans(sel_in, req_offset);
  assign beat1   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = req_bad ? ST_RESP : ST_RD0;
      ST_RD0:   state_d = ST_WAIT0;
`ifdef LOAD_MISALIGN_EN
      ST_WAIT0: if (mem_rvalid) state_d = spans(sel_q, off_q) ? ST_RD1 : ST_RESP;
      ST_RD1:   state_d = ST_WAIT1;
      ST_WAIT1: if (mem_rvalid) state_d = ST_RESP;
`else
      ST_WAIT0: if (mem_rvalid) state_d = ST_RESP;
`endif
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Beats are cleared on accept so a single-beat load sees zero above beat0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= SEL_LB;
      off_q   <= '0;
      err_q   <= 1'b0;
      beat0_q <= '0;
`ifdef LOAD_MISALIGN_EN
      beat1_q <= '0;
`endif
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        sel_q   <= sel_in;
        off_q   <= req_offset;
        err_q   <= req_bad;
        beat0_q <= '0;
`ifdef LOAD_MISALIGN_EN
        beat1_q <= '0;
`endif
      end
      if (state_q == ST_WAIT0 && mem_rvalid) beat0_q <= mem_rdata;
`ifdef LOAD_MISALIGN_EN
      if (state_q == ST_WAIT1 && mem_rvalid) beat1_q <= mem_rdata;
`endif
    end
  end

  load_extend_core #(.XLEN(XLEN)) u_ext (
    .beats  ({beat1, beat0_q}),
    .offset (off_q),
    .sel    (sel_q),
    .result (ext)
  );

  // All datapath inputs are registered and frozen in RESP, so the result is stable.
  assign req_ready = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_RD0) || (state_q == ST_RD1);
  assign mem_next  = (state_q == ST_RD1);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = (rsp_valid && !err_q) ? ext : '0;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed table-driven bench for load_align_unit (XLEN=64), with reset-abort sequence.
module tb_load_align_unit;
  localparam int XLEN = 64;
  localparam int OFFW = 3;

  logic            clk, rst_n, req_valid, req_ready;
  logic [2:0]      req_sel;
  logic [OFFW-1:0] req_offset;
  logic            mem_req, mem_next, mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [XLEN-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  load_align_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_offset(req_offset),
    .mem_req(mem_req), .mem_next(mem_next), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [2:0]  off;
    logic [63:0] b0;
    logic [63:0] b1;
    logic [63:0] data;
    logic        err;
    int          nreq;
    logic [3:0]  seq;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [2:0] off,
                              input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] data, input logic err, input int nreq,
                              input logic [3:0] seq, input int lat, input int hold);
    vec_t v;
    v.sel = sel; v.off = off; v.b0 = b0; v.b1 = b1; v.data = data; v.err = err;
    v.nreq = nreq; v.seq = seq; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int lat = 0;
    int nreq = 0;
    logic [3:0] seq = 4'd0;
    bit pend = 1'b0;
    bit pnext = 1'b0;
    bit got = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", idx), 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_sel = v.sel; req_offset = v.off;
    @(posedge clk);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      mem_rvalid = 1'b0;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pnext ? v.b1 : v.b0;
        pend = 1'b0;
      end
      if (rsp_valid) got = 1'b1;
      else if (mem_req) begin
        nreq++;
        seq = {seq[2:0], mem_next};
        pend = 1'b1;
        pnext = mem_next;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL v%0d_timeout: no rsp_valid within 40 cycles", idx);
      return;
    end
    chk($sformatf("v%0d_data", idx), rsp_data, v.data);
    chk($sformatf("v%0d_err", idx), 64'(rsp_err), 64'(v.err));
    chk($sformatf("v%0d_nreq", idx), 64'(nreq), 64'(v.nreq));
    chk($sformatf("v%0d_next_seq", idx), 64'(seq), 64'(v.seq));
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    // Backpressure: competing request and spurious read data must not disturb RESP.
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1; req_sel = 3'd3; req_offset = 3'd0;
      mem_rvalid = 1'b1; mem_rdata = 64'hA5A5_5A5A_DEAD_BEEF;
      @(negedge clk);
      chk($sformatf("v%0d_hold%0d_valid", idx, h), 64'(rsp_valid), 64'd1);
      chk($sformatf("v%0d_hold%0d_data", idx, h), rsp_data, v.data);
      chk($sformatf("v%0d_hold%0d_err", idx, h), 64'(rsp_err), 64'(v.err));
      chk($sformatf("v%0d_hold%0d_ready", idx, h), 64'(req_ready), 64'd0);
      chk($sformatf("v%0d_hold%0d_memreq", idx, h), 64'(mem_req), 64'd0);
    end
    req_valid = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_done_valid", idx), 64'(rsp_valid), 64'd0);
    chk($sformatf("v%0d_done_ready", idx), 64'(req_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_mem_req"},   64'(mem_req),   64'd0);
    chk({tag, "_mem_next"},  64'(mem_next),  64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"},  rsp_data,       64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
  endtask

  initial begin
    vecs[0] = mk(3'd3, 3'd3, 64'h0000_0000_8000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 4'd0, 3, 0);
    vecs[1] = mk(3'd5, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0, 64'h0000_0000_0000_BEEF, 1'b0, 1, 4'd0, 3, 0);
`ifdef LOAD_MISALIGN_EN
    vecs[2] = mk(3'd1, 3'd6, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_AABB, 64'hFFFF_FFFF_AABB_1122, 1'b0, 2, 4'd1, 5, 0);
    vecs[6] = mk(3'd2, 3'd7, 64'h1200_0000_0000_0000, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_8012, 1'b0, 2, 4'd1, 5, 0);
    vecs[9] = mk(3'd0, 3'd1, 64'h0807_0605_0403_0201, 64'h100F_0E0D_0C0B_0A09, 64'h0908_0706_0504_0302, 1'b0, 2, 4'd1, 5, 5);
`else
    vecs[2] = mk(3'd1, 3'd6, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_AABB, 64'h0, 1'b1, 0, 4'd0, 1, 0);
    vecs[6] = mk(3'd2, 3'd7, 64'h1200_0000_0000_0000, 64'h0000_0000_0000_0080, 64'h0, 1'b1, 0, 4'd0, 1, 0);
    vecs[9] = mk(3'd0, 3'd1, 64'h0807_0605_0403_0201, 64'h100F_0E0D_0C0B_0A09, 64'h0, 1'b1, 0, 4'd0, 1, 5);
`endif
    vecs[3]  = mk(3'd7, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 0, 4'd0, 1, 3);
    vecs[4]  = mk(3'd0, 3'd0, 64'h8000_0000_0000_0001, 64'h0, 64'h8000_0000_0000_0001, 1'b0, 1, 4'd0, 3, 0);
    vecs[5]  = mk(3'd4, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, 1, 4'd0, 3, 0);
    vecs[7]  = mk(3'd6, 3'd7, 64'hF000_0000_0000_0000, 64'h0, 64'h0000_0000_0000_00F0, 1'b0, 1, 4'd0, 3, 0);
    vecs[8]  = mk(3'd3, 3'd0, 64'h0000_0000_0000_007F, 64'h0, 64'h0000_0000_0000_007F, 1'b0, 1, 4'd0, 3, 0);
    vecs[10] = mk(3'd1, 3'd4, 64'h8000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, 4'd0, 3, 0);

    rst_n = 1'b0; req_valid = 1'b0; req_sel = 3'd0; req_offset = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run(vecs[i], i);

    // Abort a load in WAIT0, then return stale read data after reset.
    @(negedge clk);
    req_valid = 1'b1; req_sel = 3'd0; req_offset = 3'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rd0_memreq", 64'(mem_req), 64'd1);
    @(negedge clk);
    chk("abort_wait0_memreq", 64'(mem_req), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_reset_outputs($sformatf("stale%0d", k));
      @(negedge clk);
    end

    run(vecs[0], 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential load-path unit between the data-memory port and the register write-back mux.
- Accepts a load request carrying the selector and the byte offset within the memory word.
- Fetches one or two memory words, aligns the addressed bytes, then sign- or zero-extends them to XLEN.
- Parametrised successor of the fixed 64-bit load extender: adds variable XLEN, byte-offset alignment, word-spanning (misaligned) loads and valid/ready handshakes.

Parameters:
XLEN, 64, data width; legal values 32 or 64.
OFFW, $clog2(XLEN/8), byte-offset width (derived; not overridden).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  load request valid.
req_ready  out  1  unit can accept a request (IDLE only).
req_sel  in  3  0=LD 1=LW 2=LH 3=LB 4=LWU 5=LHU 6=LBU 7=illegal.
req_offset  in  OFFW  byte offset of the first byte within the word.
mem_req  out  1  one-cycle read strobe.
mem_next  out  1  with mem_req: 0=base word, 1=base word+1.
mem_rvalid  in  1  read data valid (latency >=1 after mem_req).
mem_rdata  in  XLEN  read word, little-endian bytes.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accepts result.
rsp_data  out  XLEN  aligned, extended result.
rsp_err  out  1  illegal selector, or unsupported misaligned access.

Behaviour:
- Reset (asynchronous, any state): FSM returns to IDLE.
  - Reset values: req_ready=1, mem_req=0, mem_next=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Beat registers are cleared.
- Access size by selector: LD=8, LW/LWU=4, LH/LHU=2, LB/LBU=1 bytes.
- Illegal selectors: sel 7 is illegal for any XLEN. When XLEN=32, LD and LWU are also illegal.
- Spanning condition: offset+size > XLEN/8.
- States: IDLE, RD0, WAIT0, RD1, WAIT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch sel and offset.
  - If illegal: go to RESP with err=1, data=0. No memory access.
  - Otherwise go to RD0.
- RD0: mem_req=1 and mem_next=0 for exactly one cycle, then WAIT0.
- WAIT0:
  - Ignores all cycles until mem_rvalid; then captures beat0.
  - If spanning: go to RD1 (if misalignment is supported), else to RESP.
- RD1: mem_req=1 and mem_next=1 for exactly one cycle, then WAIT1.
- WAIT1: on mem_rvalid, capture beat1, then RESP.
- Result computation (registered on entry to RESP):
  - Form {beat1, beat0} (beat1=0 when not spanning).
  - Shift right by offset*8.
  - Keep the low size*8 bits.
  - Signed selectors replicate the top kept bit to XLEN; unsigned selectors zero-fill.
- RESP:
  - rsp_valid=1. rsp_data and rsp_err stay stable until rsp_ready.
  - On rsp_ready, return to IDLE. The next request can be accepted the following cycle.
- mem_rvalid in IDLE, RD0, RD1 or RESP is ignored, including stale data returning after reset.
- Minimum latency, aligned load with 1-cycle memory: accept at t0, mem_req at t1, rvalid at t2, rsp_valid at t3.
  - A spanning load adds 2 cycles.

Optional Feature:
- Macro: LOAD_MISALIGN_EN.
- Defined: spanning loads perform the two-beat sequence (RD1/WAIT1) and return correct data with rsp_err=0.
- Undefined:
  - A spanning legal request goes straight from IDLE to RESP with rsp_err=1 and rsp_data=0.
  - No mem_req is issued.
  - RD1/WAIT1 and the beat1 register are not built.

Decomposition:
- Shared package load_pkg contains:
  - enum load_sel_e (LD..LBU, ILLEGAL=7).
  - Function load_size(sel) returning the byte count.
  - Function load_signed(sel).
  - FSM state enum load_state_e.
- Sub-module load_extend_core: purely combinational shift/mask/extend.
  - Inputs: 2*XLEN concatenated beats, offset, sel.
  - Output: XLEN result.
  - Reused by the store-path bench model.

Test Plan:
- XLEN=64, LB offset 3, beat0=0x0000_0000_8000_0000 -> rsp_data=0xFFFF_FFFF_FFFF_FF80, err=0, exactly one mem_req with mem_next=0, rsp_valid 3 cycles after accept.
- LHU offset 6, beat0=0xBEEF_0000_0000_0000 -> rsp_data=0x0000_0000_0000_BEEF.
- LW offset 6, beat0=0x1122_3344_5566_7788, beat1=0x0000_0000_0000_AABB:
  - With LOAD_MISALIGN_EN: two mem_req (next=0 then 1), rsp_data=0xFFFF_FFFF_AABB_1122.
  - Without: no mem_req, err=1, data=0.
- req_sel=7 -> no mem_req, rsp_err=1, rsp_data=0; req_ready stays low until rsp_ready.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> data/err stable, req_ready=0, new req_valid not accepted. Add a spurious mem_rvalid during RESP -> result unchanged.
- Assert rst_n low during WAIT0, release, then deliver a late mem_rvalid -> FSM in IDLE, all outputs at reset values, no rsp_valid.
